// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor. Two WIDTH-bit operands are added (or B is
//   subtracted from A) DIGIT bits per clock through a registered ripple slice.
//   The carry is held in a flop between cycles. Operands are accepted with a
//   valid/ready handshake and the result is returned with a second one.
//
// Parameters
//   WIDTH : operand/result width in bits (>= 1)
//   DIGIT : bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_valid  in   operand set presented
//   in_ready  out  block can accept operands (IDLE only)
//   a, b      in   operands, sampled only at the accept edge
//   cin       in   carry-in, ignored when sub=1
//   sub       in   0 = A+B+cin, 1 = A-B
//   out_valid out  result available
//   out_ready in   consumer accepts result
//   sum       out  result
//   cout      out  carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   ovf       out  signed two's-complement overflow
//   busy      out  operation in progress or result pending
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NSTEP = WIDTH / DIGIT;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   // Reject parameter sets the shift datapath cannot represent.
   generate
      if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
         $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              carry_r;
   logic [CW-1:0]     cnt_r;
   logic [WIDTH-1:0]  sum_r;
   logic              cout_r;
   logic              ovf_r;
   logic              out_valid_r;
   logic              in_ready_r;
   logic              busy_r;

   logic [DIGIT-1:0]  digit_s;
   logic              c_s;
   logic              cmsb_s;
   logic [1:0]        fa_s;
   logic [WIDTH-1:0]  sum_next_s;

   // One full-adder cell: returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      full_add = {((x & y) | (ci & (x ^ y))), (x ^ y ^ ci)};
   endfunction

   // DIGIT-bit ripple over the low operand bits; cmsb_s ends up as the carry
   // into the top cell of the slice, which on the final step is bit WIDTH-1.
   always_comb begin
      c_s     = carry_r;
      digit_s = '0;
      cmsb_s  = 1'b0;
      fa_s    = 2'b00;
      for (int i = 0; i < DIGIT; i++) begin
         cmsb_s     = c_s;
         fa_s       = full_add(a_r[i], b_r[i], c_s);
         digit_s[i] = fa_s[0];
         c_s        = fa_s[1];
      end
   end

   // New result digit enters at the top, so after NSTEP shifts the LSB digit
   // computed first has reached bit 0.
   generate
      if (DIGIT == WIDTH) begin : g_single
         always_comb begin
            sum_next_s = digit_s;
         end
      end else begin : g_multi
         always_comb begin
            sum_next_s = {digit_s, sum_r[WIDTH-1:DIGIT]};
         end
      end
   endgenerate

   // Control FSM plus operand/result datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         a_r         <= '0;
         b_r         <= '0;
         carry_r     <= 1'b0;
         cnt_r       <= '0;
         sum_r       <= '0;
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
               if (in_valid && in_ready_r) begin
                  a_r        <= a;
                  // Subtract as A + ~B + 1; the +1 rides in on the carry flop.
                  b_r        <= sub ? ~b : b;
                  carry_r    <= sub ? 1'b1 : cin;
                  cnt_r      <= '0;
                  state_r    <= S_RUN;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            S_RUN: begin
               a_r     <= a_r >> DIGIT;
               b_r     <= b_r >> DIGIT;
               carry_r <= c_s;
               sum_r   <= sum_next_s;
               cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == CW'(NSTEP - 1)) begin
                  state_r     <= S_DONE;
                  cout_r      <= c_s;
                  ovf_r       <= cmsb_s ^ c_s;
                  out_valid_r <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_r     <= S_IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder. Three instances share operand buses:
//   WIDTH=8/DIGIT=1, WIDTH=16/DIGIT=4 and WIDTH=4/DIGIT=4 (single-step case).
//   Each instance has its own in_valid; dsel picks which one is observed.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  iv;
   logic [15:0] a_t;
   logic [15:0] b_t;
   logic        cin_t;
   logic        sub_t;
   logic        ordy;

   logic        ir8, ov8, c8, v8, bz8;
   logic [7:0]  s8;
   logic        ir16, ov16, c16, v16, bz16;
   logic [15:0] s16;
   logic        ir4, ov4, c4, v4, bz4;
   logic [3:0]  s4;

   int          dsel = 0;
   logic        o_valid, o_ready, o_busy, o_cout, o_ovf;
   logic [15:0] o_sum;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir8),
      .a(a_t[7:0]), .b(b_t[7:0]), .cin(cin_t), .sub(sub_t),
      .out_valid(ov8), .out_ready(ordy), .sum(s8), .cout(c8), .ovf(v8), .busy(bz8));

   serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir16),
      .a(a_t), .b(b_t), .cin(cin_t), .sub(sub_t),
      .out_valid(ov16), .out_ready(ordy), .sum(s16), .cout(c16), .ovf(v16), .busy(bz16));

   serial_adder #(.WIDTH(4), .DIGIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir4),
      .a(a_t[3:0]), .b(b_t[3:0]), .cin(cin_t), .sub(sub_t),
      .out_valid(ov4), .out_ready(ordy), .sum(s4), .cout(c4), .ovf(v4), .busy(bz4));

   // Observe the selected instance.
   always_comb begin
      o_valid = ov8;
      o_ready = ir8;
      o_busy  = bz8;
      o_sum   = {8'h00, s8};
      o_cout  = c8;
      o_ovf   = v8;
      case (dsel)
         1: begin
            o_valid = ov16; o_ready = ir16; o_busy = bz16;
            o_sum = s16; o_cout = c16; o_ovf = v16;
         end
         2: begin
            o_valid = ov4; o_ready = ir4; o_busy = bz4;
            o_sum = {12'h000, s4}; o_cout = c4; o_ovf = v4;
         end
         default: begin
         end
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic int nsteps(input int d);
      if (d == 1) return 4;
      else if (d == 2) return 1;
      else return 8;
   endfunction

   // Called at a negedge with the selected instance idle. Returns at a negedge.
   task automatic run_op(input int d, input logic [15:0] ta, input logic [15:0] tb,
                         input logic ci, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo, input string nm);
      int lat;
      dsel  = d;
      a_t   = ta;
      b_t   = tb;
      cin_t = ci;
      sub_t = sb;
      iv    = 3'b001 << d;
      #1;
      check({nm, " in_ready"}, {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs after the accept edge: result must not depend on them.
      iv    = 3'b000;
      a_t   = ~ta;
      b_t   = 16'h5a5a;
      cin_t = ~ci;
      sub_t = ~sb;
      check({nm, " busy"}, {31'd0, o_busy}, 32'd1);
      check({nm, " in_ready_run"}, {31'd0, o_ready}, 32'd0);
      lat = 0;
      while ((o_valid !== 1'b1) && (lat < nsteps(d) + 10)) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, lat, nsteps(d));
      check({nm, " sum"}, {16'd0, o_sum}, {16'd0, es});
      check({nm, " cout"}, {31'd0, o_cout}, {31'd0, ec});
      check({nm, " ovf"}, {31'd0, o_ovf}, {31'd0, eo});
      if (ordy) begin
         @(negedge clk);
         check({nm, " out_valid_drop"}, {31'd0, o_valid}, 32'd0);
         check({nm, " in_ready_back"}, {31'd0, o_ready}, 32'd1);
      end
   endtask

   typedef struct {
      int          d;
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic        sb;
      logic [15:0] s;
      logic        c;
      logic        o;
      string       nm;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc[$];
      int   bad;
      logic [15:0] held;

      vecs[0]  = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ff_plus_01"};
      vecs[1]  = '{0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, "7f_plus_01"};
      vecs[2]  = '{0, 16'h0080, 16'h00FF, 1'b0, 1'b0, 16'h007F, 1'b1, 1'b1, "80_plus_ff"};
      vecs[3]  = '{0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'h00FE, 1'b0, 1'b0, "05_minus_07"};
      vecs[4]  = '{0, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "07_minus_05"};
      vecs[5]  = '{0, 16'h0012, 16'h0034, 1'b1, 1'b0, 16'h0047, 1'b0, 1'b0, "12_34_cin"};
      vecs[6]  = '{0, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, "80_minus_01"};
      vecs[7]  = '{0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "zero_cin"};
      vecs[8]  = '{1, 16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, "w16_0fff_cin"};
      vecs[9]  = '{1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "w16_plain"};
      vecs[10] = '{1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "w16_sub_ovf"};
      vecs[11] = '{1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1, "w16_add_ovf"};
      vecs[12] = '{2, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, "w4_ovf"};
      vecs[13] = '{2, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, "w4_sub"};
      vecs[14] = '{2, 16'h000F, 16'h000F, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0, "w4_cin"};

      rst_n = 1'b0; iv = 3'b000; ordy = 1'b1;
      a_t = 16'h0000; b_t = 16'h0000; cin_t = 1'b0; sub_t = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      dsel = 0;
      check("rst out_valid", {31'd0, o_valid}, 32'd0);
      check("rst sum", {16'd0, o_sum}, 32'd0);
      check("rst cout", {31'd0, o_cout}, 32'd0);
      check("rst ovf", {31'd0, o_ovf}, 32'd0);
      check("rst busy", {31'd0, o_busy}, 32'd0);
      check("rst in_ready", {31'd0, o_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel in_ready", {31'd0, o_ready}, 32'd1);

      // Table-driven vectors, out_ready held high
      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
                vecs[i].s, vecs[i].c, vecs[i].o, vecs[i].nm);
      end

      // Backpressure: result must hold, in_valid pulses must be ignored
      ordy = 1'b0;
      run_op(0, 16'h0033, 16'h0044, 1'b0, 1'b0, 16'h0077, 1'b0, 1'b0, "bp");
      for (int k = 0; k < 5; k++) begin
         iv  = (k % 2 == 0) ? 3'b001 : 3'b000;
         a_t = 16'h0001;
         @(negedge clk);
         check("bp out_valid", {31'd0, o_valid}, 32'd1);
         check("bp sum", {16'd0, o_sum}, 32'h77);
         check("bp cout_ovf", {30'd0, o_cout, o_ovf}, 32'd0);
         check("bp in_ready", {31'd0, o_ready}, 32'd0);
      end
      iv   = 3'b000;
      ordy = 1'b1;
      @(negedge clk);
      check("bp release out_valid", {31'd0, o_valid}, 32'd0);
      check("bp release in_ready", {31'd0, o_ready}, 32'd1);
      @(negedge clk);
      check("bp no new op", {31'd0, o_busy}, 32'd0);

      // Reset in the middle of RUN
      dsel = 0; a_t = 16'h0055; b_t = 16'h0022; cin_t = 1'b0; sub_t = 1'b0;
      iv = 3'b001;
      @(posedge clk);
      @(negedge clk);
      iv = 3'b000;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst out_valid", {31'd0, o_valid}, 32'd0);
      check("mid_rst sum", {16'd0, o_sum}, 32'd0);
      check("mid_rst busy", {31'd0, o_busy}, 32'd0);
      check("mid_rst in_ready", {31'd0, o_ready}, 32'd0);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (o_valid !== 1'b0 || o_busy !== 1'b0) bad++;
      end
      check("mid_rst no stale result", bad, 0);
      run_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0, "after_rst");

      // Back-to-back on the 16/4 instance: accepts every NSTEP+2 = 6 cycles
      dsel = 1; a_t = 16'h0FFF; b_t = 16'h0001; cin_t = 1'b1; sub_t = 1'b0;
      ordy = 1'b1;
      iv = 3'b010;
      for (int cyc = 0; cyc < 18; cyc++) begin
         if (o_ready === 1'b1) acc.push_back(cyc);
         if (o_valid === 1'b1) begin
            held = o_sum;
            check("b2b sum", {16'd0, held}, 32'h1001);
         end
         @(negedge clk);
      end
      iv = 3'b000;
      repeat (8) @(negedge clk);
      check("b2b accept count", acc.size(), 3);
      for (int k = 1; k < acc.size(); k++) begin
         check("b2b interval", acc[k] - acc[k-1], 6);
      end
      check("b2b idle", {31'd0, o_busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full-adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through a registered ripple slice, with the carry held in a flop between cycles.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits between operand-producing datapath blocks and result consumers wherever area matters more than latency.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be at least 1.
- DIGIT, 1: bits processed per cycle. Must divide WIDTH exactly; elaboration error otherwise.
- NSTEP, WIDTH/DIGIT: derived local parameter, the cycle count per operation. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = add, 1 = subtract (A-B).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. For subtract: 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block.
- Reset values: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, carry flop=0, step counter=0. in_ready is 0 while rst_n is low and 1 from the first cycle after reset is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a and b into shift registers. Latch b as ~b when sub=1.
  - Load the carry flop with (sub ? 1 : cin). Clear the step counter. Go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: add the low DIGIT bits of A, the low DIGIT bits of B, and the carry flop through a DIGIT-bit ripple of full-adder cells.
  - Shift the DIGIT result bits into the top of the sum register (LSB digit first). Update the carry flop and shift the operand registers right by DIGIT.
  - Increment the counter. At the edge where counter==NSTEP-1, go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are stable and must not change while out_valid=1 & out_ready=0.
  - On out_valid & out_ready: go to IDLE. out_valid drops on the same edge.
  - in_ready returns to 1 in the following cycle; there is no overlap between consecutive operations.
- Latency: the first edge with out_valid=1 comes exactly NSTEP edges after the accepting edge. Throughput is one operation per NSTEP+2 cycles when out_ready is held high.
- cout: final carry out of bit WIDTH-1.
- ovf: carry into MSB XOR carry out of MSB. Capture it on the final RUN edge.
- Operands on a/b/cin/sub are sampled only at the accept edge; later changes have no effect.
- in_valid while not in IDLE: ignored, nothing queued.
- out_ready asserted outside DONE: ignored.
- Reset mid-operation (RUN or DONE): on the next edge everything returns to reset values. The partial result is discarded and out_valid is never raised for the aborted operation.
- WIDTH==DIGIT (NSTEP=1): a single RUN cycle; the same rules apply.

Test Plan:
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0, sub=0 -> after exactly 8 cycles, out_valid=1, sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, add -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0xFF, add -> sum=0x7F, cout=1, ovf=1.
- Subtract: a=0x05, b=0x07, sub=1 (cin=1 ignored) -> sum=0xFE, cout=0, ovf=0. Then a=0x07, b=0x05 -> sum=0x02, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf constant and in_ready=0 throughout. Pulsing in_valid during this window must not start a new operation.
- Reset mid-RUN: drop rst_n at step 3 of 8 -> next cycle out_valid=0, sum=0, busy=0. After release, in_ready=1 and a fresh 0x12+0x34 gives 0x46 after 8 cycles.
- WIDTH=16, DIGIT=4: a=0x0FFF, b=0x0001, cin=1 -> out_valid after exactly 4 cycles, sum=0x1001, cout=0. Back-to-back operations with out_ready=1 are accepted every 6 cycles.
